// File: rtl/hash_feed_pkg.sv
// Shared types and constants for the hash core message feeder.
package hash_feed_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEND     = 3'd2,
    GAP      = 3'd3,
    WAIT_DIG = 3'd4,
    OUT      = 3'd5
  } feed_state_e;

  // Per-byte processing latency of the hash core
  localparam int         HC_BYTE_CYCLES = 3;
  localparam logic [7:0] ASCII_MIN      = 8'h20;
  localparam logic [7:0] ASCII_MAX      = 8'h7E;

  // Digest response as presented on the output handshake
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } dig_rsp_t;

  function automatic logic is_ascii(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/hash_feed_pacer.sv
// Down-counter shared by byte pacing and digest timeout.
// Loaded with N, it reports expired on the (N+1)-th cycle after the load.
module hash_feed_pacer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/hash_msg_feeder.sv
// Host-side feeder for the DES-S-box hash core: paces a byte stream onto
// the core port, waits for the digest and returns it with an error flag.
// Optional: HASH_FEED_ASCII_CHECK_EN flags bytes outside 0x20..0x7E as errors.
module hash_msg_feeder
  import hash_feed_pkg::*;
#(
  parameter int BYTE_GAP = 3,
  parameter int TIMEOUT  = 16,
  parameter int LEN_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             hc_m_valid,
  output logic [7:0]       hc_message,
  output logic [LEN_W-1:0] hc_counter,
  input  logic [31:0]      hc_digest,
  input  logic             hc_hash_ready,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [31:0]      dig_data,
  output logic             dig_err
);

  localparam int PACE_MAX = (TIMEOUT > BYTE_GAP) ? TIMEOUT : BYTE_GAP;
  localparam int PACE_W   = $clog2(PACE_MAX + 1);

  if (BYTE_GAP < HC_BYTE_CYCLES) begin : g_bad_gap
    $error("hash_msg_feeder: BYTE_GAP must be >= HC_BYTE_CYCLES");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("hash_msg_feeder: TIMEOUT must be >= 1");
  end

  feed_state_e      state;
  logic [LEN_W-1:0] rem;
  logic             err;
  dig_rsp_t         rsp;

  logic              pace_load;
  logic [PACE_W-1:0] pace_val;
  logic              pace_exp;

  // Pacer reload: gap count on SEND, timeout window on entry to WAIT_DIG
  always_comb begin
    pace_load = 1'b0;
    pace_val  = '0;
    if (state == SEND) begin
      pace_load = 1'b1;
      pace_val  = PACE_W'(BYTE_GAP - 2);
    end else if (state == GAP && pace_exp && rem == '0) begin
      pace_load = 1'b1;
      pace_val  = PACE_W'(TIMEOUT - 1);
    end
  end

  hash_feed_pacer #(.CNT_W(PACE_W)) u_pacer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pace_load),
    .load_val (pace_val),
    .expired  (pace_exp)
  );

  assign dig_data = rsp.data;
  assign dig_err  = rsp.err;

  // Main sequencer; all handshake and core-port outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      s_ready    <= 1'b0;
      hc_m_valid <= 1'b0;
      hc_message <= '0;
      hc_counter <= '0;
      rem        <= '0;
      err        <= 1'b0;
      dig_valid  <= 1'b0;
      rsp        <= '0;
    end else begin
      hc_m_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          rem        <= cmd_len;
          hc_counter <= cmd_len;
          cmd_ready  <= 1'b0;
          if (cmd_len == '0) begin
            err       <= 1'b1;
            rsp       <= '{err: 1'b1, data: 32'h0};
            dig_valid <= 1'b1;
            state     <= OUT;
          end else begin
            err     <= 1'b0;
            s_ready <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: if (s_valid) begin
          hc_message <= s_data;
          hc_m_valid <= 1'b1;
          s_ready    <= 1'b0;
          state      <= SEND;
          // Framing mismatch is recorded, but cmd_len still decides length
          if (s_last != (rem == LEN_W'(1))) err <= 1'b1;
`ifdef HASH_FEED_ASCII_CHECK_EN
          if (!is_ascii(s_data)) err <= 1'b1;
`endif
        end
        SEND: begin
          if (rem != '0) rem <= rem - LEN_W'(1);
          state <= GAP;
        end
        GAP: if (pace_exp) begin
          if (rem == '0) begin
            state <= WAIT_DIG;
          end else begin
            s_ready <= 1'b1;
            state   <= LOAD;
          end
        end
        WAIT_DIG: begin
          if (hc_hash_ready) begin
            rsp       <= '{err: err, data: hc_digest};
            dig_valid <= 1'b1;
            state     <= OUT;
          end else if (pace_exp) begin
            err       <= 1'b1;
            rsp       <= '{err: 1'b1, data: 32'h0};
            dig_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: if (dig_ready) begin
          dig_valid <= 1'b0;
          rsp       <= '0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          s_ready   <= 1'b0;
          dig_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder with a behavioural hash core and a scoreboard.
module tb_hash_msg_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_len = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        hc_m_valid;
  logic [7:0]  hc_message;
  logic [63:0] hc_counter;
  logic [31:0] hc_digest;
  logic        hc_hash_ready;
  logic        dig_valid;
  logic        dig_ready = 1'b0;
  logic [31:0] dig_data;
  logic        dig_err;

  hash_msg_feeder #(.BYTE_GAP(3), .TIMEOUT(16), .LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .hc_m_valid(hc_m_valid), .hc_message(hc_message), .hc_counter(hc_counter),
    .hc_digest(hc_digest), .hc_hash_ready(hc_hash_ready),
    .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig_data(dig_data), .dig_err(dig_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } sb_item_t;

  sb_item_t    sb[$];
  time         pulse_t[$];
  time         t_acc;
  time         dig_rise_t;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_len = '0;
  bit          core_mute = 1'b0;
  bit          rdy_mode  = 1'b0;
  bit          rdy_force = 1'b0;
  logic [7:0]  mb [16];
  bit          ml [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden hash of the behavioural core
  function automatic logic [31:0] hstep(input logic [31:0] d, input logic [7:0] b);
    return ({d[26:0], d[31:27]} ^ {24'h0, b}) * 32'h0100_0193;
  endfunction
  function automatic logic [31:0] hseed(input logic [63:0] c);
    return 32'h811C_9DC5 ^ c[31:0];
  endfunction
  function automatic logic [31:0] ref_hash(input int len);
    logic [31:0] d = hseed(64'(len));
    for (int i = 0; i < len; i++) d = hstep(d, mb[i]);
    return d;
  endfunction

  // Behavioural core: clears ready on a message's first byte, raises it 3 cycles after the last
  logic [63:0] core_seen;
  logic [31:0] core_acc;
  int          core_dly;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_hash_ready <= 1'b0;
      hc_digest     <= '0;
      core_seen     <= '0;
      core_acc      <= '0;
      core_dly      <= 0;
    end else begin
      if (hc_m_valid) begin
        if (core_seen == 0) hc_hash_ready <= 1'b0;
        core_acc <= hstep((core_seen == 0) ? hseed(hc_counter) : core_acc, hc_message);
        if (core_seen + 1 == hc_counter) begin
          core_seen <= '0;
          core_dly  <= 3;
        end else begin
          core_seen <= core_seen + 1;
        end
      end
      if (core_dly != 0) begin
        core_dly <= core_dly - 1;
        if (core_dly == 1 && !core_mute) begin
          hc_hash_ready <= 1'b1;
          hc_digest     <= core_acc;
        end
      end
    end
  end

  // Consumer ready: random unless the stimulus takes control
  initial forever begin
    @(posedge clk);
    #1;
    dig_ready = rdy_mode ? rdy_force : ($urandom_range(0, 2) != 0);
  end

  // Monitor: core-port pulses, output hold stability, scoreboard pops
  initial begin
    bit          prev_v = 1'b0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_e = 1'b0;
    sb_item_t    e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (hc_m_valid) begin
          pulse_t.push_back($time);
          chk("hc_counter", hc_counter, exp_len);
        end
        if (dig_valid && !prev_v) dig_rise_t = $time;
        if (hold_pend) begin
          chk("hold_valid", {63'h0, dig_valid}, 64'h1);
          chk("hold_data", {32'h0, dig_data}, {32'h0, hold_d});
          chk("hold_err", {63'h0, dig_err}, {63'h0, hold_e});
        end
        if (dig_valid && dig_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_dig", 64'h1, 64'h0);
          end else begin
            e = sb.pop_front();
            chk("dig_data", {32'h0, dig_data}, {32'h0, e.data});
            chk("dig_err", {63'h0, dig_err}, {63'h0, e.err});
          end
        end
        hold_pend = dig_valid && !dig_ready;
        hold_d    = dig_data;
        hold_e    = dig_err;
        prev_v    = dig_valid;
      end
    end
  end

  // One message: expectation from the message rules, then drive command and bytes.
  // abort_after>0 resets the DUT after that many bytes and expects no result.
  task automatic run_msg(input int len, input bit eager, input int abort_after);
    sb_item_t e;
    int       n;
    bit       err;
    pulse_t.delete();
    exp_len = 64'(len);
    err = (len == 0) || core_mute;
    for (int i = 0; i < len; i++) begin
      if (ml[i] != (i == len - 1)) err = 1'b1;
`ifdef HASH_FEED_ASCII_CHECK_EN
      if (mb[i] < 8'h20 || mb[i] > 8'h7E) err = 1'b1;
`endif
    end
    e.err  = err;
    e.data = (len == 0 || core_mute) ? 32'h0 : ref_hash(len);
    if (abort_after == 0) sb.push_back(e);

    if (eager && len > 0) begin
      s_valid = 1'b1; s_data = mb[0]; s_last = ml[0];
    end
    cmd_valid = 1'b1;
    cmd_len   = 64'(len);
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'h0, 64'h1);
    @(posedge clk);
    t_acc = $time;
    #1 cmd_valid = 1'b0;

    for (int i = 0; i < len; i++) begin
      if (!eager && i > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_valid = 1'b1; s_data = mb[i]; s_last = ml[i];
      n = 0;
      while (!s_ready && n < 200) begin @(negedge clk); n++; end
      if (!s_ready) chk("s_ready_timeout", 64'h0, 64'h1);
      @(posedge clk);
      #1;
      if (!eager || i == len - 1) s_valid = 1'b0;
      if (abort_after != 0 && i == abort_after - 1) begin
        s_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        chk("rst_dig_valid", {63'h0, dig_valid}, 64'h0);
        chk("rst_s_ready", {63'h0, s_ready}, 64'h0);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_pulses", 64'(pulse_t.size()), 64'(abort_after));
        return;
      end
    end

    n = 0;
    while ((sb.size() != 0 || dig_valid) && n < 400) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 64'h0);
    chk("pulse_count", 64'(pulse_t.size()), 64'(len));
    for (int i = 1; i < pulse_t.size(); i++)
      if (pulse_t[i] - pulse_t[i-1] < 40) chk("pulse_spacing", 64'(pulse_t[i] - pulse_t[i-1]), 64'd40);
  endtask

  initial begin
    int len;
    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    chk("rst_s_ready", {63'h0, s_ready}, 64'h0);
    chk("rst_hc_m_valid", {63'h0, hc_m_valid}, 64'h0);
    chk("rst_hc_counter", hc_counter, 64'h0);
    chk("rst_dig_valid", {63'h0, dig_valid}, 64'h0);
    chk("rst_dig_data", {32'h0, dig_data}, 64'h0);
    chk("rst_dig_err", {63'h0, dig_err}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte
    mb[0] = 8'h41; ml[0] = 1'b1;
    run_msg(1, 1'b0, 0);

    // "abc", s_valid held high: 2-cycle first latency, 4-cycle spacing
    mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63;
    ml[0] = 1'b0;  ml[1] = 1'b0;  ml[2] = 1'b1;
    run_msg(3, 1'b1, 0);
    if (pulse_t.size() == 3) begin
      chk("first_latency", 64'(pulse_t[0] - t_acc), 64'd15);
      chk("eager_gap01", 64'(pulse_t[1] - pulse_t[0]), 64'd40);
      chk("eager_gap12", 64'(pulse_t[2] - pulse_t[1]), 64'd40);
    end

    // Zero length
    run_msg(0, 1'b0, 0);
    chk("zero_len_latency", 64'(dig_rise_t - t_acc), 64'd5);

    // s_last early on a 2-byte message
    mb[0] = 8'h30; mb[1] = 8'h31; ml[0] = 1'b1; ml[1] = 1'b0;
    run_msg(2, 1'b0, 0);

    // Core never answers: timeout, then consumer stalls 5 cycles
    core_mute = 1'b1;
    rdy_mode  = 1'b1;
    rdy_force = 1'b0;
    mb[0] = 8'h5A; ml[0] = 1'b1;
    fork
      run_msg(1, 1'b0, 0);
      begin
        int n = 0;
        while (!dig_valid && n < 300) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        rdy_force = 1'b1;
      end
    join
    if (pulse_t.size() == 1) chk("timeout_latency", 64'(dig_rise_t - pulse_t[0]), 64'd190);
    core_mute = 1'b0;
    rdy_mode  = 1'b0;

    // Reset after the 2nd of 5 bytes
    for (int i = 0; i < 5; i++) begin mb[i] = 8'h40 + 8'(i); ml[i] = (i == 4); end
    run_msg(5, 1'b0, 2);

    // Following message, with a control byte inside
    mb[0] = 8'h48; mb[1] = 8'h0A; mb[2] = 8'h49;
    ml[0] = 1'b0;  ml[1] = 1'b0;  ml[2] = 1'b1;
    run_msg(3, 1'b0, 0);

    // Random messages
    for (int m = 0; m < 10; m++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        mb[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(32, 126));
        ml[i] = (i == len - 1);
      end
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(0, len - 1);
        ml[k] = !ml[k];
      end
      run_msg(len, 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
